// File: rtl/tl_ul_reg_responder_if.sv
// TL-UL A/D channel bundle between a requester and the register responder.
// master drives A and d_ready; slave drives a_ready and the D beat.
interface tl_ul_reg_responder_if #(
  parameter int ADDR_W = 9
);
  logic              in_a_ready;
  logic              in_a_valid;
  logic [2:0]        in_a_bits_opcode;
  logic [ADDR_W-1:0] in_a_bits_address;
  logic [3:0]        in_a_bits_mask;
  logic [31:0]       in_a_bits_data;
  logic              in_d_ready;
  logic              in_d_valid;
  logic [2:0]        in_d_bits_opcode;
  logic              in_d_bits_denied;
  logic [31:0]       in_d_bits_data;
  logic              in_d_bits_corrupt;

  modport master (
    input  in_a_ready,
    output in_a_valid,
    output in_a_bits_opcode,
    output in_a_bits_address,
    output in_a_bits_mask,
    output in_a_bits_data,
    output in_d_ready,
    input  in_d_valid,
    input  in_d_bits_opcode,
    input  in_d_bits_denied,
    input  in_d_bits_data,
    input  in_d_bits_corrupt
  );

  modport slave (
    output in_a_ready,
    input  in_a_valid,
    input  in_a_bits_opcode,
    input  in_a_bits_address,
    input  in_a_bits_mask,
    input  in_a_bits_data,
    input  in_d_ready,
    output in_d_valid,
    output in_d_bits_opcode,
    output in_d_bits_denied,
    output in_d_bits_data,
    output in_d_bits_corrupt
  );
endinterface

// File: rtl/tl_ul_reg_responder.sv
// TL-UL manager for a 32-bit register bank, one transaction in flight.
// Ports: clock, reset (async, high), tl (slave A/D bundle), busy.
module tl_ul_reg_responder #(
  parameter int          ADDR_W     = 9,
  parameter int          NUM_REGS   = 16,
  parameter int          RESP_DELAY = 2,
  parameter logic [31:0] ID_VALUE   = 32'h5853_0001
) (
  input  logic                 clock,
  input  logic                 reset,
  tl_ul_reg_responder_if.slave tl,
  output logic                 busy
);

  localparam int IW = ADDR_W - 2;
  localparam int CW = (RESP_DELAY > 1) ? $clog2(RESP_DELAY) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  logic [31:0] regs [1:NUM_REGS-1];

  logic [2:0]  d_op;
  logic        d_den;
  logic        d_cor;
  logic [31:0] d_data;

  logic          accept;
  logic [IW-1:0] idx;
  logic          mapped;
  logic          is_get;
  logic          is_put;
  logic          wr_ok;
  logic [31:0]   rd_word;
  logic [31:0]   wmask;

  logic [2:0]  rsp_op;
  logic        rsp_den;
  logic        rsp_cor;
  logic [31:0] rsp_data;

  assign accept = tl.in_a_valid && tl.in_a_ready;
  assign idx    = tl.in_a_bits_address[ADDR_W-1:2];
  assign mapped = (tl.in_a_bits_address[1:0] == 2'b00)
               && (int'(idx) < NUM_REGS);
  assign is_get = (tl.in_a_bits_opcode == 3'd4);
  assign is_put = (tl.in_a_bits_opcode == 3'd0)
               || (tl.in_a_bits_opcode == 3'd1);
  assign wr_ok  = is_put && mapped && (idx != '0);

  // Register 0 is the read-only ID word; it has no storage.
  always_comb begin
    rd_word = ID_VALUE;
    for (int i = 1; i < NUM_REGS; i++)
      if (idx == IW'(i))
        rd_word = regs[i];
  end

  // PutFullData ignores the mask and writes every lane.
  always_comb begin
    wmask = '0;
    for (int b = 0; b < 4; b++)
      wmask[8*b +: 8] = {8{(tl.in_a_bits_opcode == 3'd0)
                           || tl.in_a_bits_mask[b]}};
  end

  always_comb begin
    rsp_op   = 3'd0;
    rsp_den  = 1'b0;
    rsp_cor  = 1'b0;
    rsp_data = '0;
    unique case (1'b1)
      is_get && mapped: begin
        rsp_op   = 3'd1;
        rsp_data = rd_word;
      end
      is_get && !mapped: begin
        rsp_op  = 3'd1;
        rsp_den = 1'b1;
        rsp_cor = 1'b1;
      end
      wr_ok: begin
        rsp_op = 3'd0;
      end
      !is_get && !wr_ok: begin
        rsp_den = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 1; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else if (accept && wr_ok) begin
      for (int i = 1; i < NUM_REGS; i++)
        if (idx == IW'(i))
          regs[i] <= (regs[i] & ~wmask)
                   | (tl.in_a_bits_data & wmask);
    end
  end

  // The whole D beat is captured at acceptance so later writes
  // cannot disturb a response that is still waiting or stalled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      d_op   <= '0;
      d_den  <= 1'b0;
      d_cor  <= 1'b0;
      d_data <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            d_op   <= rsp_op;
            d_den  <= rsp_den;
            d_cor  <= rsp_cor;
            d_data <= rsp_data;
            if (RESP_DELAY == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= CW'(RESP_DELAY - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == '0)
            state <= RESP;
          else
            cnt <= cnt - CW'(1);
        end
        RESP: begin
          if (tl.in_d_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign tl.in_a_ready        = (state == IDLE);
  assign tl.in_d_valid        = (state == RESP);
  assign tl.in_d_bits_opcode  = d_op;
  assign tl.in_d_bits_denied  = d_den;
  assign tl.in_d_bits_corrupt = d_cor;
  assign tl.in_d_bits_data    = d_data;
  assign busy                 = (state != IDLE);

endmodule

// File: tb/tb_tl_ul_reg_responder.sv
// Randomized and directed checks of tl_ul_reg_responder against
// a register-array reference model; RESP_DELAY 2 and 0 instances.
module tb_tl_ul_reg_responder;

  localparam logic [31:0] ID = 32'h5853_0001;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tl_ul_reg_responder_if #(.ADDR_W(9)) bus0 ();
  tl_ul_reg_responder_if #(.ADDR_W(9)) bus1 ();
  logic busy0;
  logic busy1;

  tl_ul_reg_responder #(
    .ADDR_W(9), .NUM_REGS(16), .RESP_DELAY(2), .ID_VALUE(ID)
  ) dut (
    .clock(clk), .reset(rst), .tl(bus0.slave), .busy(busy0)
  );

  tl_ul_reg_responder #(
    .ADDR_W(9), .NUM_REGS(16), .RESP_DELAY(0), .ID_VALUE(ID)
  ) dut_z (
    .clock(clk), .reset(rst), .tl(bus1.slave), .busy(busy1)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] m [16];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m[0] = ID;
    for (int i = 1; i < 16; i++) m[i] = '0;
  endtask

  task automatic model(input logic [2:0] op, input logic [8:0] addr,
                       input logic [3:0] mask, input logic [31:0] data,
                       output logic [2:0] e_op, output logic [31:0] e_data,
                       output logic e_den, output logic e_cor);
    int  idx;
    bit  ok;
    idx = int'(addr) / 4;
    ok  = (int'(addr) % 4 == 0) && (idx < 16);
    e_op = 3'd0; e_data = '0; e_den = 1'b1; e_cor = 1'b0;
    if (op == 3'd4) begin
      e_op = 3'd1;
      if (ok) begin
        e_data = m[idx]; e_den = 1'b0;
      end else begin
        e_cor = 1'b1;
      end
    end else if ((op == 3'd0 || op == 3'd1) && ok && idx != 0) begin
      e_den = 1'b0;
      for (int b = 0; b < 4; b++)
        if (op == 3'd0 || mask[b])
          m[idx][8*b +: 8] = data[8*b +: 8];
    end
  endtask

  task automatic chk_d(input string tag, input logic [2:0] e_op,
                       input logic [31:0] e_data, input logic e_den,
                       input logic e_cor);
    chk({tag, "_valid"}, 32'(bus0.in_d_valid), 32'd1);
    chk({tag, "_op"}, 32'(bus0.in_d_bits_opcode), 32'(e_op));
    chk({tag, "_data"}, bus0.in_d_bits_data, e_data);
    chk({tag, "_den"}, 32'(bus0.in_d_bits_denied), 32'(e_den));
    chk({tag, "_cor"}, 32'(bus0.in_d_bits_corrupt), 32'(e_cor));
  endtask

  task automatic xfer(input logic [2:0] op, input logic [8:0] addr,
                      input logic [3:0] mask, input logic [31:0] data,
                      input int bp, output logic [31:0] got);
    logic [2:0]  e_op;
    logic [31:0] e_data;
    logic        e_den;
    logic        e_cor;
    int          n;
    got = '0;
    model(op, addr, mask, data, e_op, e_data, e_den, e_cor);
    @(negedge clk);
    bus0.in_a_valid        = 1'b1;
    bus0.in_a_bits_opcode  = op;
    bus0.in_a_bits_address = addr;
    bus0.in_a_bits_mask    = mask;
    bus0.in_a_bits_data    = data;
    n = 0;
    while (!bus0.in_a_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus0.in_a_ready) begin
      chk("a_timeout", 32'd0, 32'd1);
      bus0.in_a_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus0.in_a_valid = 1'b0;
    n = 1;
    while (!bus0.in_d_valid && n < 50) begin
      chk("wait_a_rdy", 32'(bus0.in_a_ready), 32'd0);
      chk("wait_busy", 32'(busy0), 32'd1);
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'd3);
    if (!bus0.in_d_valid) begin
      chk("d_timeout", 32'd0, 32'd1);
      return;
    end
    for (int k = 0; k < bp; k++) begin
      chk_d("bp", e_op, e_data, e_den, e_cor);
      bus0.in_a_valid        = 1'b1;
      bus0.in_a_bits_opcode  = 3'd4;
      bus0.in_a_bits_address = 9'($urandom_range(0, 511));
      chk("bp_a_rdy", 32'(bus0.in_a_ready), 32'd0);
      @(negedge clk);
    end
    chk_d("d", e_op, e_data, e_den, e_cor);
    got = bus0.in_d_bits_data;
    bus0.in_d_ready = 1'b1;
    bus0.in_a_valid = 1'b0;
    @(negedge clk);
    bus0.in_d_ready = 1'b0;
    chk("d_drop", 32'(bus0.in_d_valid), 32'd0);
    chk("a_rdy_back", 32'(bus0.in_a_ready), 32'd1);
  endtask

  logic [31:0] got;
  logic [2:0]  ill [5] = '{3'd2, 3'd3, 3'd5, 3'd6, 3'd7};

  initial begin
    logic [2:0]  op;
    logic [8:0]  addr;
    int          r;
    int          acc;
    logic        prev_ar;

    rst = 1'b1;
    bus0.in_a_valid = 1'b0; bus0.in_a_bits_opcode = '0;
    bus0.in_a_bits_address = '0; bus0.in_a_bits_mask = '0;
    bus0.in_a_bits_data = '0; bus0.in_d_ready = 1'b0;
    bus1.in_a_valid = 1'b0; bus1.in_a_bits_opcode = '0;
    bus1.in_a_bits_address = '0; bus1.in_a_bits_mask = '0;
    bus1.in_a_bits_data = '0; bus1.in_d_ready = 1'b0;
    model_reset();

    @(negedge clk);
    chk("rst_a_rdy", 32'(bus0.in_a_ready), 32'd1);
    chk("rst_d_vld", 32'(bus0.in_d_valid), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_d_op", 32'(bus0.in_d_bits_opcode), 32'd0);
    chk("rst_d_data", bus0.in_d_bits_data, 32'd0);
    chk("rst_d_den", 32'(bus0.in_d_bits_denied), 32'd0);
    chk("rst_d_cor", 32'(bus0.in_d_bits_corrupt), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    xfer(3'd4, 9'h000, 4'h0, 32'h0, 0, got);
    chk("id_read", got, ID);
    xfer(3'd0, 9'h008, 4'h0, 32'hDEAD_BEEF, 0, got);
    xfer(3'd1, 9'h008, 4'b0101, 32'h1122_3344, 0, got);
    xfer(3'd4, 9'h008, 4'h0, 32'h0, 0, got);
    chk("partial_rd", got, 32'hDE22_BE44);

    xfer(3'd4, 9'h040, 4'h0, 32'h0, 0, got);
    xfer(3'd0, 9'h000, 4'hF, 32'h1234_5678, 0, got);
    xfer(3'd0, 9'h006, 4'hF, 32'h1234_5678, 0, got);
    xfer(3'd2, 9'h004, 4'hF, 32'h1234_5678, 0, got);
    xfer(3'd4, 9'h000, 4'h0, 32'h0, 0, got);
    chk("reg0_kept", got, ID);
    xfer(3'd4, 9'h004, 4'h0, 32'h0, 0, got);
    chk("reg1_kept", got, 32'h0);

    xfer(3'd4, 9'h008, 4'h0, 32'h0, 5, got);
    chk("bp_rd", got, 32'hDE22_BE44);

    for (int t = 0; t < 40; t++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4)      op = 3'd4;
      else if (r < 6) op = 3'd0;
      else if (r < 8) op = 3'd1;
      else            op = ill[$urandom_range(0, 4)];
      if ($urandom_range(0, 9) < 8)
        addr = {3'b000, 4'($urandom_range(0, 15)), 2'b00};
      else
        addr = 9'($urandom_range(0, 511));
      xfer(op, addr, 4'($urandom), $urandom, int'($urandom_range(0, 3)),
           got);
    end

    @(negedge clk);
    bus1.in_a_bits_opcode  = 3'd4;
    bus1.in_a_bits_address = 9'h000;
    bus1.in_a_valid        = 1'b1;
    bus1.in_d_ready        = 1'b1;
    prev_ar = bus1.in_a_ready;
    chk("z_start", 32'(prev_ar), 32'd1);
    acc = 0;
    for (int k = 0; k < 12; k++) begin
      if (prev_ar) acc++;
      @(negedge clk);
      chk("z_d_after_acc", 32'(bus1.in_d_valid), 32'(prev_ar));
      chk("z_alternate", 32'(bus1.in_a_ready), 32'(!prev_ar));
      if (bus1.in_d_valid)
        chk("z_data", bus1.in_d_bits_data, ID);
      prev_ar = bus1.in_a_ready;
    end
    bus1.in_a_valid = 1'b0;
    chk("z_rate", 32'(acc), 32'd6);
    @(negedge clk);
    bus1.in_d_ready = 1'b0;

    @(negedge clk);
    chk("mr_idle", 32'(bus0.in_a_ready), 32'd1);
    bus0.in_a_valid        = 1'b1;
    bus0.in_a_bits_opcode  = 3'd0;
    bus0.in_a_bits_address = 9'h00C;
    bus0.in_a_bits_data    = 32'hCAFE_F00D;
    @(posedge clk);
    @(negedge clk);
    bus0.in_a_valid = 1'b0;
    chk("mr_busy", 32'(busy0), 32'd1);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mr_busy_clr", 32'(busy0), 32'd0);
    chk("mr_a_rdy", 32'(bus0.in_a_ready), 32'd1);
    for (int k = 0; k < 6; k++) begin
      chk("mr_no_d", 32'(bus0.in_d_valid), 32'd0);
      @(negedge clk);
    end
    xfer(3'd4, 9'h00C, 4'h0, 32'h0, 0, got);
    chk("mr_reg3", got, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
